// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Word/amount widths, direction codes and FSM state encoding.
package shift_sequencer_pkg;

  localparam int word_size = 32;
  localparam int amt_size  = $clog2(word_size);

  localparam logic LEFT  = 1'b1;
  localparam logic RIGHT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step_counter.sv
// Loadable down-counter tracking remaining 1-bit shift steps.
// Ports: clk, rst, load, dec, load_value in; is_one out.
module shift_step_counter
  import shift_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [amt_size-1:0] load_value,
  output logic                is_one
);

  logic [amt_size-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == amt_size'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Drives a single-step shifter once per clock to build an N-bit shift.
// Ports: start/direction/amount/data_in request, busy/done/result, sh_* shifter link.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 direction,
  input  logic [amt_size-1:0]  amount,
  input  logic [word_size-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] result,
  output logic                 sh_enable,
  output logic                 sh_direction,
  output logic [word_size-1:0] sh_data,
  input  logic [word_size-1:0] sh_result
);

  state_t               state;
  logic                 dir_r;
  logic [word_size-1:0] work;
  logic                 is_one;
  logic                 accept;

  assign accept = (state == IDLE) && start;

  shift_step_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .dec        (state == SHIFT),
    .load_value (amount),
    .is_one     (is_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dir_r  <= RIGHT;
      work   <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dir_r <= direction;
            work  <= data_in;
            if (amount != '0) begin
              state <= SHIFT;
            end else begin
              state  <= DONE;
              result <= data_in;
            end
          end
        end
        SHIFT: begin
          work <= sh_result;
          // Last step: capture the shifter output directly so
          // result is valid in the DONE cycle.
          if (is_one) begin
            state  <= DONE;
            result <= sh_result;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign sh_enable    = (state == SHIFT);
  assign sh_direction = dir_r;
  assign sh_data      = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a 1-bit shifter model.
// Scoreboard queue holds expected results pushed at request time.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 direction;
  logic [amt_size-1:0]  amount;
  logic [word_size-1:0] data_in;
  logic                 busy;
  logic                 done;
  logic [word_size-1:0] result;
  logic                 sh_enable;
  logic                 sh_direction;
  logic [word_size-1:0] sh_data;
  logic [word_size-1:0] sh_result;

  int tests = 0;
  int fails = 0;
  logic [word_size-1:0] exp_q[$];

  typedef struct {
    logic                 d;
    logic [amt_size-1:0]  a;
    logic [word_size-1:0] x;
  } op_t;

  always #5 clk = ~clk;

  // External single-step shifter: pass-through when not enabled.
  assign sh_result = !sh_enable ? sh_data :
                     (sh_direction ? (sh_data << 1) : (sh_data >> 1));

  shift_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .direction    (direction),
    .amount       (amount),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .sh_enable    (sh_enable),
    .sh_direction (sh_direction),
    .sh_data      (sh_data),
    .sh_result    (sh_result)
  );

  function automatic logic [word_size-1:0] model(
    input logic d, input logic [amt_size-1:0] a,
    input logic [word_size-1:0] x);
    return d ? (x << a) : (x >> a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic d, input logic [amt_size-1:0] a,
                       input logic [word_size-1:0] x);
    start     = 1'b1;
    direction = d;
    amount    = a;
    data_in   = x;
    exp_q.push_back(model(d, a, x));
  endtask

  // Counts edges until done; lat is the edge count at which done is seen.
  task automatic wait_done(input bit hold, output int lat, output int en);
    lat = 0;
    en  = 0;
    do begin
      step();
      lat++;
      if (!hold) start = 1'b0;
      if (sh_enable) en++;
    end while (!done && lat < 200);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    direction = 1'b0;
    amount = '0;
    data_in = '0;
    step();
    step();
    tests++;
    if ({busy, done, sh_enable, sh_direction} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0000",
               {busy, done, sh_enable, sh_direction});
    end
    tests++;
    if (result !== '0) begin
      fails++;
      $display("FAIL reset_result got %h want 0", result);
    end
    tests++;
    if (sh_data !== '0) begin
      fails++;
      $display("FAIL reset_sh_data got %h want 0", sh_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_ops();
    op_t ops[$];
    int lat, en;
    logic [word_size-1:0] exp;
    ops.push_back('{LEFT,  5'd4,  32'h0000_0001});
    ops.push_back('{RIGHT, 5'd31, 32'h8000_0000});
    ops.push_back('{LEFT,  5'd31, 32'hFFFF_FFFF});
    ops.push_back('{RIGHT, 5'd0,  32'hDEAD_BEEF});
    ops.push_back('{RIGHT, 5'd7,  32'hF0F0_1234});
    for (int i = 0; i < 4; i++)
      ops.push_back('{1'($urandom_range(1)), 5'($urandom_range(31)),
                      32'($urandom)});
    foreach (ops[i]) begin
      issue(ops[i].d, ops[i].a, ops[i].x);
      wait_done(1'b0, lat, en);
      exp = exp_q.pop_front();
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL op%0d_timeout done=%b want 1", i, done);
      end
      tests++;
      if (lat != int'(ops[i].a) + 1) begin
        fails++;
        $display("FAIL op%0d_latency got %0d want %0d",
                 i, lat, int'(ops[i].a) + 1);
      end
      tests++;
      if (result !== exp) begin
        fails++;
        $display("FAIL op%0d_result got %h want %h", i, result, exp);
      end
      tests++;
      if (en != int'(ops[i].a)) begin
        fails++;
        $display("FAIL op%0d_sh_enable_cycles got %0d want %0d",
                 i, en, ops[i].a);
      end
      step();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL op%0d_after_done busy=%b done=%b want 0 0",
                 i, busy, done);
      end
    end
  endtask

  task automatic test_hold_result();
    int lat, en;
    logic [word_size-1:0] exp;
    bit changed;
    issue(RIGHT, 5'd3, 32'h0000_0F00);
    wait_done(1'b0, lat, en);
    exp = exp_q.pop_front();
    changed = 1'b0;
    data_in = 32'h5555_5555;
    for (int i = 0; i < 6; i++) begin
      step();
      if (result !== exp) changed = 1'b1;
    end
    tests++;
    if (changed) begin
      fails++;
      $display("FAIL hold_result got %h want %h", result, exp);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, en;
    bit extra;
    logic [word_size-1:0] exp;
    issue(LEFT, 5'd3, 32'h0000_00F0);
    step();
    start = 1'b0;
    step();
    start     = 1'b1;
    direction = RIGHT;
    amount    = 5'd1;
    data_in   = 32'h1234_5678;
    step();
    start = 1'b0;
    wait_done(1'b0, lat, en);
    exp = exp_q.pop_front();
    tests++;
    if (lat != 1 || !done) begin
      fails++;
      $display("FAIL busy_latency got %0d done=%b want 1 1", lat, done);
    end
    tests++;
    if (result !== exp) begin
      fails++;
      $display("FAIL busy_result got %h want %h", result, exp);
    end
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) extra = 1'b1;
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL busy_queued got 1 want 0");
    end
    issue(RIGHT, 5'd2, 32'h0000_0100);
    wait_done(1'b0, lat, en);
    exp = exp_q.pop_front();
    tests++;
    if (result !== exp || lat != 3) begin
      fails++;
      $display("FAIL busy_next got %h/%0d want %h/3", result, lat, exp);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int lat, en;
    bit seen;
    logic [word_size-1:0] exp;
    issue(LEFT, 5'd8, 32'h0000_0001);
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sh_enable !== 1'b0) begin
      fails++;
      $display("FAIL midrst_ctrl busy=%b done=%b en=%b want 0 0 0",
               busy, done, sh_enable);
    end
    tests++;
    if (result !== '0 || sh_data !== '0) begin
      fails++;
      $display("FAIL midrst_data got %h/%h want 0/0", result, sh_data);
    end
    rst = 1'b0;
    void'(exp_q.pop_front());
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midrst_done got 1 want 0");
    end
    issue(RIGHT, 5'd5, 32'hA5A5_0000);
    wait_done(1'b0, lat, en);
    exp = exp_q.pop_front();
    tests++;
    if (result !== exp || lat != 6 || en != 5) begin
      fails++;
      $display("FAIL midrst_fresh got %h/%0d/%0d want %h/6/5",
               result, lat, en, exp);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [word_size-1:0] vals[4];
    logic [word_size-1:0] exp;
    int lat, en;
    vals[0] = 32'h0000_0003;
    vals[1] = 32'h8000_0001;
    vals[2] = 32'h1234_5678;
    vals[3] = 32'hFFFF_0000;
    issue(LEFT, 5'd2, vals[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b1, lat, en);
      exp = exp_q.pop_front();
      if (i < 3) issue(LEFT, 5'd2, vals[i+1]);
      else start = 1'b0;
      tests++;
      if (lat != ((i == 0) ? 3 : 4) || !done) begin
        fails++;
        $display("FAIL b2b%0d_period got %0d want %0d",
                 i, lat, (i == 0) ? 3 : 4);
      end
      tests++;
      if (result !== exp || en != 2) begin
        fails++;
        $display("FAIL b2b%0d_result got %h/%0d want %h/2",
                 i, result, en, exp);
      end
    end
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle busy=%b want 0", busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ops();
    test_hold_result();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the single-step barrel shifter. It accepts a shift request with an arbitrary amount (0 to word_size-1) and direction. It then drives the shifter once per clock, feeding each step's output back as the next step's input, until the requested amount is reached. It sits between the instruction decode/execute control and the shifter, turning the shifter's fixed 1-bit shift into an N-bit logical shift with a start/done handshake.

## Interface
- word_size, 32, data width; must match the shifter's word_size
- amt_size, $clog2(word_size) (5), width of the shift-amount field
- LEFT, 1, direction encoding for left shift
- RIGHT, 0, direction encoding for right shift

Ports:
- clk  input  1  sole clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- direction  input  1  LEFT/RIGHT; sampled with start
- amount  input  amt_size  number of 1-bit steps; sampled with start
- data_in  input  word_size  operand; sampled with start
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; result valid in this cycle
- result  output  word_size  shifted value; held until the next accepted start
- sh_enable  output  1  to shifter_enable
- sh_direction  output  1  to shift_direction
- sh_data  output  word_size  to the shifter data input
- sh_result  input  word_size  from shifter_out (combinational, same cycle)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch direction into dir_r, data_in into work, amount into count.
  - Go to SHIFT if amount != 0, else go to DONE.
- IDLE, start=0: remain in IDLE.
- SHIFT, each cycle:
  - sh_enable=1, sh_direction=dir_r, sh_data=work.
  - work <= sh_result; count <= count-1.
  - If count==1, go to DONE.
- DONE: done=1, result=work (registered copy); next state IDLE.
- Outside SHIFT: sh_enable=0, sh_data=work, sh_direction=dir_r. The shifter then passes data through unchanged.
- Shifts are logical and zero-fill: LEFT gives data<<amount, RIGHT gives data>>amount. No rotation or sign extension.
- start while busy: ignored, no queueing; the in-flight operation is unaffected.
- amount=0: result=data_in; done still pulses.
- Reset mid-operation:
  - Next cycle is IDLE, busy=0, done=0.
  - No done pulse for the aborted request.
  - result=0, work=0, count=0, dir_r=RIGHT.
- Reset values: busy=0, done=0, result=0, sh_enable=0, sh_direction=0, sh_data=0.

## Timing
- start accepted at edge T (state IDLE) → done=1 during cycle T+amount+1.
- busy is high from cycle T+1 through the done cycle inclusive. busy=0 in the cycle after done.
- Earliest next acceptance is the first IDLE cycle after DONE. Request-to-request throughput is amount+2 cycles.
- sh_enable is high for exactly amount consecutive cycles per request.
- result changes only at the edge entering DONE, or on reset.
- sh_result is sampled in the same cycle sh_data is driven; no shifter latency is assumed.

## Structure
- Shared package:
  - word_size and amt_size
  - LEFT/RIGHT direction constants
  - 2-bit state encoding: IDLE=0, SHIFT=1, DONE=2
- The single-step shifter stays outside this block and is connected at the level above.
- One natural sub-module: shift_step_counter. It is a loadable amt_size down-counter with load, decrement and is_one outputs.
- Everything else is the FSM plus the work, dir_r and result registers.

## Test plan
- Left shift: data_in=32'h0000_0001, LEFT, amount=4 → done at T+5, result=32'h0000_0010, sh_enable high for exactly 4 cycles.
- Right shift, full span: data_in=32'h8000_0000, RIGHT, amount=31 → done at T+32, result=32'h0000_0001. A second run with amount=31 LEFT on 32'hFFFF_FFFF gives 32'h8000_0000.
- Zero amount: data_in=32'hDEAD_BEEF, amount=0 → done at T+1, result=32'hDEAD_BEEF, sh_enable never asserted.
- Start while busy: second start with different data at T+2 of an amount=3 op → ignored. Result matches the first request; the next request is accepted only after busy drops.
- Reset mid-operation: rst=1 at T+2 of an amount=8 op → IDLE next cycle, busy=0, result=0, no done pulse. A fresh request afterwards completes normally.
- Back-to-back: start held high continuously with amount=2 → a done pulse every 4 cycles, each result correct.
